// File: rtl/gfx_rom_pkg.sv
// gfx_rom_pkg: shared types and constants for the graphics ROM arbiter.
// Arbiter states, client ids, default region bases, timeout fill word.
package gfx_rom_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {CL_TILE, CL_SPR, CL_THEME} client_t;

   localparam logic [21:0] TILE_BASE_DEF  = 22'h000000;
   localparam logic [21:0] SPR_BASE_DEF   = 22'h040000;
   localparam logic [21:0] THEME_BASE_DEF = 22'h0C0000;
   localparam logic [31:0] TIMEOUT_FILL   = 32'hFFFFFFFF;

   function automatic logic [15:0] half_of(
      input logic [31:0] w,
      input logic        hi
   );
      return hi ? w[31:16] : w[15:0];
   endfunction

endpackage

// File: rtl/gfx_rom_arbiter_prio_sel.sv
// gfx_rom_prio_sel: combinational winner select for the ROM arbiter.
// Starved requesters win first (theme > spr > tile), else tile > spr > theme.
module gfx_rom_prio_sel
   import gfx_rom_pkg::*;
#(
   parameter int CW         = 3,
   parameter int STARVE_MAX = 4
) (
   input  logic [2:0]         req,
   input  logic [2:0][CW-1:0] starve,
   output logic               any_req,
   output client_t            winner
);

   logic [2:0] promo;

   assign promo[0] = req[0] && (starve[0] >= CW'(STARVE_MAX));
   assign promo[1] = req[1] && (starve[1] >= CW'(STARVE_MAX));
   assign promo[2] = req[2] && (starve[2] >= CW'(STARVE_MAX));
   assign any_req  = |req;

   always_comb begin
      if (promo[2])      winner = CL_THEME;
      else if (promo[1]) winner = CL_SPR;
      else if (promo[0]) winner = CL_TILE;
      else if (req[0])   winner = CL_TILE;
      else if (req[1])   winner = CL_SPR;
      else if (req[2])   winner = CL_THEME;
      else               winner = CL_TILE;
   end

endmodule

// File: rtl/gfx_rom_arbiter.sv
// gfx_rom_arbiter: shares one 32-bit ROM port between tile, sprite, theme.
// Optional per-client last-word hit cache: define GFX_ROM_HITCACHE_EN.
module gfx_rom_arbiter
   import gfx_rom_pkg::*;
#(
   parameter int                MEM_AW     = 22,
   parameter logic [MEM_AW-1:0] TILE_BASE  = MEM_AW'(TILE_BASE_DEF),
   parameter logic [MEM_AW-1:0] SPR_BASE   = MEM_AW'(SPR_BASE_DEF),
   parameter logic [MEM_AW-1:0] THEME_BASE = MEM_AW'(THEME_BASE_DEF),
   parameter int                STARVE_MAX = 4,
   parameter int                TIMEOUT    = 63
) (
   input  logic              clk_sys,
   input  logic              nRESET,
   input  logic              tile_req,
   input  logic [17:0]       tile_addr,
   output logic              tile_ack,
   output logic [31:0]       tile_data,
   input  logic              spr_req,
   input  logic [18:0]       spr_addr,
   output logic              spr_ack,
   output logic [31:0]       spr_data,
   input  logic              theme_req,
   input  logic [17:0]       theme_addr,
   output logic              theme_ack,
   output logic [15:0]       theme_data,
   output logic              mem_rd,
   output logic [MEM_AW-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic              mem_valid,
   input  logic [31:0]       mem_dout,
   output logic              busy,
   output logic              err
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t             state;
   client_t            cur;
   client_t            gnt;
   logic               any_req;
   logic               half;
   logic               hit;
   logic               hit_q;
   logic [31:0]        hit_word;
   logic [TW-1:0]      tcnt;
   logic [2:0][CW-1:0] starve;
   logic [2:0]         req_v;
   logic [MEM_AW-1:0]  map_w;
   logic               timeout;
   logic               dlv;
   logic [31:0]        dword;

   assign req_v = {theme_req, spr_req, tile_req};
   assign busy  = (state != IDLE);

   gfx_rom_prio_sel #(
      .CW         (CW),
      .STARVE_MAX (STARVE_MAX)
   ) u_prio (
      .req     (req_v),
      .starve  (starve),
      .any_req (any_req),
      .winner  (gnt)
   );

   always_comb begin
      unique case (gnt)
         CL_SPR:   map_w = SPR_BASE + MEM_AW'(spr_addr);
         CL_THEME: map_w = THEME_BASE + MEM_AW'(theme_addr[17:1]);
         default:  map_w = TILE_BASE + MEM_AW'(tile_addr);
      endcase
   end

   // a real mem_valid beats the watchdog on its last cycle
   assign timeout = (state == WAIT) && !mem_valid &&
                    (tcnt == TW'(TIMEOUT));

   always_comb begin
      dlv   = 1'b0;
      dword = mem_dout;
      if (state == ISSUE && hit_q) begin
         dlv   = 1'b1;
         dword = hit_word;
      end else if (state == WAIT && mem_valid) begin
         dlv   = 1'b1;
      end else if (timeout) begin
         dlv   = 1'b1;
         dword = TIMEOUT_FILL;
      end
   end

`ifdef GFX_ROM_HITCACHE_EN
   logic [2:0]                  hc_vld;
   logic [2:0][MEM_AW-1:0]      hc_addr;
   logic [2:0][31:0]            hc_data;

   assign hit      = hc_vld[gnt] && (hc_addr[gnt] == map_w);
   assign hit_word = hc_data[cur];

   always_ff @(posedge clk_sys) begin
      if (!nRESET) begin
         hc_vld <= '0;
      end else if (state == WAIT && mem_valid) begin
         hc_vld[cur]  <= 1'b1;
         hc_addr[cur] <= mem_addr;
         hc_data[cur] <= mem_dout;
      end else if (timeout) begin
         hc_vld[cur]  <= 1'b0;
      end
   end
`else
   assign hit      = 1'b0;
   assign hit_word = '0;
`endif

   always_ff @(posedge clk_sys) begin
      if (!nRESET) begin
         state      <= IDLE;
         cur        <= CL_TILE;
         half       <= 1'b0;
         hit_q      <= 1'b0;
         tcnt       <= '0;
         starve     <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         tile_ack   <= 1'b0;
         spr_ack    <= 1'b0;
         theme_ack  <= 1'b0;
         tile_data  <= '0;
         spr_data   <= '0;
         theme_data <= '0;
         err        <= 1'b0;
      end else begin
         tile_ack  <= 1'b0;
         spr_ack   <= 1'b0;
         theme_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= ISSUE;
                  cur      <= gnt;
                  half     <= theme_addr[0];
                  mem_addr <= map_w;
                  mem_rd   <= !hit;
                  hit_q    <= hit;
                  tcnt     <= '0;
                  for (int i = 0; i < 3; i++) begin
                     if (2'(i) == gnt)
                        starve[i] <= '0;
                     else if (req_v[i] && starve[i] < CW'(STARVE_MAX))
                        starve[i] <= starve[i] + 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (!hit_q && mem_ready) begin
                  mem_rd <= 1'b0;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (!dlv) tcnt <= tcnt + 1'b1;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
         if (dlv) begin
            state <= RESP;
            unique case (cur)
               CL_SPR: begin
                  spr_ack  <= 1'b1;
                  spr_data <= dword;
               end
               CL_THEME: begin
                  theme_ack  <= 1'b1;
                  theme_data <= half_of(dword, half);
               end
               default: begin
                  tile_ack  <= 1'b1;
                  tile_data <= dword;
               end
            endcase
         end
         if (timeout) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// Bench for gfx_rom_arbiter: vector table, corner sequences and
// random traffic checked against a transaction-level reference model.
module tb_gfx_rom_arbiter;

   localparam int TMO  = 63;
   localparam int SMAX = 4;

   logic        clk_sys = 1'b0;
   logic        nRESET;
   logic        tile_req, spr_req, theme_req;
   logic [17:0] tile_addr, theme_addr;
   logic [18:0] spr_addr;
   logic        tile_ack, spr_ack, theme_ack;
   logic [31:0] tile_data, spr_data;
   logic [15:0] theme_data;
   logic        mem_rd, mem_ready, mem_valid;
   logic [21:0] mem_addr;
   logic [31:0] mem_dout;
   logic        busy, err;

   gfx_rom_arbiter dut (
      .clk_sys    (clk_sys),
      .nRESET     (nRESET),
      .tile_req   (tile_req),
      .tile_addr  (tile_addr),
      .tile_ack   (tile_ack),
      .tile_data  (tile_data),
      .spr_req    (spr_req),
      .spr_addr   (spr_addr),
      .spr_ack    (spr_ack),
      .spr_data   (spr_data),
      .theme_req  (theme_req),
      .theme_addr (theme_addr),
      .theme_ack  (theme_ack),
      .theme_data (theme_data),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_valid  (mem_valid),
      .mem_dout   (mem_dout),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;
   int cnt [3];
`ifdef GFX_ROM_HITCACHE_EN
   bit          mh_vld  [3];
   logic [21:0] mh_addr [3];
   logic [31:0] mh_word [3];
`endif

   typedef struct {
      logic [2:0]  mask;
      logic [17:0] ta;
      logic [18:0] sa;
      logic [17:0] ha;
      int          lat;
      logic [31:0] dout;
      logic [21:0] ea;
      logic [31:0] ed;
      int          ew;
   } vec_t;

   vec_t vt [10];

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // spec arbitration rule: starved requesters first, then fixed order
   task automatic arb(input logic [2:0] mask, output int w);
      w = -1;
      for (int j = 2; j >= 0; j--)
         if (w < 0 && mask[j] && cnt[j] >= SMAX) w = j;
      for (int j = 0; j < 3; j++)
         if (w < 0 && mask[j]) w = j;
      for (int j = 0; j < 3; j++) begin
         if (j == w) cnt[j] = 0;
         else if (mask[j] && cnt[j] < SMAX) cnt[j]++;
      end
   endtask

   function automatic logic [21:0] map_addr(input int w);
      logic [31:0] s;
      if (w == 0)      s = 32'h000000 + 32'(tile_addr);
      else if (w == 1) s = 32'h040000 + 32'(spr_addr);
      else             s = 32'h0C0000 + 32'(theme_addr >> 1);
      return s[21:0];
   endfunction

   task automatic model_clear();
      cnt = '{0, 0, 0};
`ifdef GFX_ROM_HITCACHE_EN
      mh_vld = '{0, 0, 0};
`endif
   endtask

   task automatic mdl_store(input int w, input logic [21:0] a,
                            input logic [31:0] word, input bit ok);
`ifdef GFX_ROM_HITCACHE_EN
      mh_vld[w]  = ok;
      mh_addr[w] = a;
      mh_word[w] = word;
`endif
   endtask

   task automatic check_quiet(input string nm);
      check({nm, "_rd"}, 32'(mem_rd), 0);
      check({nm, "_addr"}, 32'(mem_addr), 0);
      check({nm, "_ack"}, 32'({tile_ack, spr_ack, theme_ack}), 0);
      check({nm, "_tdata"}, tile_data, 0);
      check({nm, "_sdata"}, spr_data, 0);
      check({nm, "_hdata"}, 32'(theme_data), 0);
      check({nm, "_busy"}, 32'(busy), 0);
      check({nm, "_err"}, 32'(err), 0);
   endtask

   task automatic xact(input logic [2:0] mask, input int lat,
                       input logic [31:0] dout, input bit give,
                       input bit hold, output int who,
                       output logic [21:0] oaddr, output logic [31:0] odata,
                       output int ocyc, output int nrd);
      int          w, ec, acc;
      logic [21:0] ea;
      logic [31:0] word, ed;
      logic        hsel;
      bit          hit, got;
      tile_req  = mask[0];
      spr_req   = mask[1];
      theme_req = mask[2];
      arb(mask, w);
      ea   = map_addr(w);
      hsel = theme_addr[0];
      hit  = 1'b0;
`ifdef GFX_ROM_HITCACHE_EN
      hit = mh_vld[w] && (mh_addr[w] == ea);
`endif
      if (hit) begin
`ifdef GFX_ROM_HITCACHE_EN
         word = mh_word[w];
`else
         word = dout;
`endif
         ec = 2;
      end else begin
         word = give ? dout : 32'hFFFFFFFF;
         ec   = give ? 2 + lat : 2 + TMO + 1;
      end
      ed = (w == 2) ? 32'(hsel ? word[31:16] : word[15:0]) : word;
      acc = -1; got = 0; who = -1; oaddr = '0; odata = '0;
      ocyc = -1; nrd = 0;
      for (int k = 0; k < 200 && !got; k++) begin
         if (k == 1 && !hold) begin
            tile_req = 0; spr_req = 0; theme_req = 0;
         end
         mem_valid = 1'b0;
         if (acc >= 0) check("rd_drop", 32'(mem_rd), 0);
         else if (mem_rd) begin
            acc = k; nrd++; oaddr = mem_addr;
         end
         if (give && acc >= 0 && k == acc + lat) begin
            mem_valid = 1'b1;
            mem_dout  = dout;
         end
         if ({theme_ack, spr_ack, tile_ack} != 3'b000) begin
            got  = 1;
            ocyc = k;
            check("ack_onehot", $countones({theme_ack, spr_ack, tile_ack}), 1);
            who  = theme_ack ? 2 : (spr_ack ? 1 : 0);
            odata = (who == 2) ? 32'(theme_data) :
                    (who == 1) ? spr_data : tile_data;
         end
         tick();
      end
      check("who", who, w);
      check("ack_cyc", ocyc, ec);
      check("data", odata, ed);
      if (hit) check("no_rd", nrd, 0);
      else begin
         check("rd_cyc", acc, 1);
         check("rd_addr", 32'(oaddr), 32'(ea));
         mdl_store(w, ea, word, give);
      end
   endtask

   task automatic do_reset();
      nRESET = 0;
      tile_req = 0; spr_req = 0; theme_req = 0;
      mem_valid = 0;
      tick(); tick();
      check_quiet("rst");
      nRESET = 1;
      model_clear();
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          who, ocyc, nrd, tot_rd;
      logic [21:0] oa;
      logic [31:0] od;
      int          last [3];
      int          exp6 [6];

      vt[0] = '{3'b001, 18'h00010, 19'h0, 18'h0, 3, 32'hCAFE0001, 22'h000010, 32'hCAFE0001, 0};
      vt[1] = '{3'b010, 18'h0, 19'h12345, 18'h0, 1, 32'h0BADF00D, 22'h052345, 32'h0BADF00D, 1};
      vt[2] = '{3'b100, 18'h0, 19'h0, 18'h00003, 2, 32'hBEEF1234, 22'h0C0001, 32'h0000BEEF, 2};
      vt[3] = '{3'b100, 18'h0, 19'h0, 18'h00002, 1, 32'hBEEF1234, 22'h0C0001, 32'h00001234, 2};
      vt[4] = '{3'b010, 18'h0, 19'h7FFFF, 18'h0, 4, 32'hA5A55A5A, 22'h0BFFFF, 32'hA5A55A5A, 1};
      vt[5] = '{3'b001, 18'h3FFFF, 19'h0, 18'h0, 2, 32'h13579BDF, 22'h03FFFF, 32'h13579BDF, 0};
      vt[6] = '{3'b100, 18'h0, 19'h0, 18'h3FFFF, 5, 32'h89ABCDEF, 22'h0DFFFF, 32'h000089AB, 2};
      vt[7] = '{3'b111, 18'h00020, 19'h00030, 18'h00041, 2, 32'h11112222, 22'h000020, 32'h11112222, 0};
      vt[8] = '{3'b110, 18'h0, 19'h00030, 18'h00041, 1, 32'h33334444, 22'h040030, 32'h33334444, 1};
      vt[9] = '{3'b100, 18'h0, 19'h0, 18'h00041, 1, 32'h55556666, 22'h0C0020, 32'h00005555, 2};

      nRESET = 0; mem_ready = 1; mem_valid = 0; mem_dout = '0;
      tile_req = 0; spr_req = 0; theme_req = 0;
      tile_addr = '0; spr_addr = '0; theme_addr = '0;
      tick();
      do_reset();

      foreach (vt[i]) begin
         tile_addr = vt[i].ta; spr_addr = vt[i].sa; theme_addr = vt[i].ha;
         xact(vt[i].mask, vt[i].lat, vt[i].dout, 1, 0, who, oa, od, ocyc, nrd);
         check("vec_who", who, vt[i].ew);
         check("vec_addr", 32'(oa), 32'(vt[i].ea));
         check("vec_data", od, vt[i].ed);
      end

      // ISSUE holds the command while the controller stalls
      spr_addr = 19'h00005;
      mem_ready = 0;
      arb(3'b010, who);
      spr_req = 1;
      tick();
      check("stall_rd1", 32'(mem_rd), 1);
      spr_req = 0;
      tick();
      check("stall_rd2", 32'(mem_rd), 1);
      check("stall_addr", 32'(mem_addr), 32'h040005);
      mem_ready = 1;
      tick();
      check("stall_drop", 32'(mem_rd), 0);
      mem_valid = 1; mem_dout = 32'h77778888;
      tick();
      mem_valid = 0;
      check("stall_ack", 32'(spr_ack), 1);
      check("stall_data", spr_data, 32'h77778888);
      mdl_store(1, 22'h040005, 32'h77778888, 1);
      tick();
      check("stall_ack_end", 32'(spr_ack), 0);
      check("stall_busy", 32'(busy), 0);

      tile_addr = 18'h00200;
      xact(3'b001, TMO + 1, 32'h24682468, 1, 0, who, oa, od, ocyc, nrd);
      check("exact_to_data", od, 32'h24682468);
      check("exact_to_err", 32'(err), 0);

      tile_addr = 18'h00300;
      xact(3'b001, 1, 32'h0, 0, 0, who, oa, od, ocyc, nrd);
      check("to_data", od, 32'hFFFFFFFF);
      check("to_cyc", ocyc, TMO + 3);
      check("to_err", 32'(err), 1);
      theme_addr = 18'h00501;
      xact(3'b100, 1, 32'h0, 0, 0, who, oa, od, ocyc, nrd);
      check("to_theme_data", od, 32'h0000FFFF);
      spr_addr = 19'h00400;
      xact(3'b010, 2, 32'h12121212, 1, 0, who, oa, od, ocyc, nrd);
      check("err_sticky", 32'(err), 1);

      // reset in WAIT, then a late mem_valid must be ignored
      tile_addr = 18'h00100;
      tile_req = 1;
      tick();
      tile_req = 0;
      tick(); tick();
      check("midrst_busy", 32'(busy), 1);
      nRESET = 0;
      tick();
      check_quiet("midrst");
      tick();
      nRESET = 1;
      model_clear();
      tick();
      mem_valid = 1; mem_dout = 32'hDEADBEEF;
      tick();
      mem_valid = 0;
      for (int k = 0; k < 5; k++) begin
         check("stray_ack", 32'({tile_ack, spr_ack, theme_ack}), 0);
         check("stray_busy", 32'(busy), 0);
         tick();
      end
      check_quiet("stray");

      tile_addr = 18'h00100; spr_addr = 19'h00200; theme_addr = 18'h00300;
      exp6 = '{0, 0, 0, 0, 2, 1};
      last = '{-1, -1, -1};
      for (int g = 0; g < 12; g++) begin
         xact(3'b111, 1, $urandom, 1, 1, who, oa, od, ocyc, nrd);
         if (g < 6) check("starve_order", who, exp6[g]);
         if (who >= 0) begin
            check("starve_gap", 32'((g - last[who] - 1) <= 5), 1);
            last[who] = g;
         end
      end
      tile_req = 0; spr_req = 0; theme_req = 0;
      tick();

      for (int r = 0; r < 150; r++) begin
         logic [2:0] m;
         bit give;
         m = 3'($urandom_range(1, 7));
         give = ($urandom_range(0, 24) != 0);
         tile_addr  = 18'($urandom);
         spr_addr   = 19'($urandom);
         theme_addr = 18'($urandom);
         xact(m, $urandom_range(1, 6), $urandom, give, 0, who, oa, od, ocyc, nrd);
      end

      spr_addr = 19'h12345;
      tot_rd = 0;
      xact(3'b010, 3, 32'h0F0F0F0F, 1, 0, who, oa, od, ocyc, nrd);
      tot_rd += nrd;
      xact(3'b010, 3, 32'h0F0F0F0F, 1, 0, who, oa, od, ocyc, nrd);
      tot_rd += nrd;
      check("repeat_data", od, 32'h0F0F0F0F);
`ifdef GFX_ROM_HITCACHE_EN
      check("repeat_reads", tot_rd, 1);
      check("repeat_cyc", ocyc, 2);
`else
      check("repeat_reads", tot_rd, 2);
      check("repeat_cyc", ocyc, 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/gfx_rom_arbiter.md
Name: gfx_rom_arbiter

Overview:
- Shares one external 32-bit read-only memory port (SDRAM controller side) between three ROM clients: tile ROM (k051962 path, 1MB), sprite ROM (k051937 path, 2MB) and theme sample ROM (512kB, 16-bit).
- Sits between the top level's tiles/spr/theme ROM address buses and the board memory controller.
- Uses fixed priority with anti-starvation, one outstanding access at a time, a watchdog timeout and per-client registered data.

Parameters:
- MEM_AW, 22, memory word-address width (32-bit words).
- TILE_BASE, 22'h000000, word base of the tile region.
- SPR_BASE, 22'h040000, word base of the sprite region.
- THEME_BASE, 22'h0C0000, word base of the theme region.
- STARVE_MAX, 4, consecutive lost arbitrations before a pending client is promoted.
- TIMEOUT, 63, cycles allowed in WAIT before the access is aborted.

Ports:
- clk_sys  in  1  system clock (96MHz); the only clock.
- nRESET  in  1  synchronous reset, active-low.
- tile_req  in  1  tile fetch request, level.
- tile_addr  in  18  tile word address.
- tile_ack  out  1  one-cycle pulse: tile_data valid.
- tile_data  out  32  tile read data, held until the next tile_ack.
- spr_req  in  1  sprite fetch request, level.
- spr_addr  in  19  sprite word address.
- spr_ack  out  1  one-cycle pulse: spr_data valid.
- spr_data  out  32  sprite read data, held until the next spr_ack.
- theme_req  in  1  theme fetch request, level.
- theme_addr  in  18  theme halfword address.
- theme_ack  out  1  one-cycle pulse: theme_data valid.
- theme_data  out  16  theme read data, held until the next theme_ack.
- mem_rd  out  1  read command to the memory controller.
- mem_addr  out  MEM_AW  memory word address.
- mem_ready  in  1  controller accepts mem_rd this cycle.
- mem_valid  in  1  mem_dout valid, one-cycle pulse.
- mem_dout  in  32  memory read data.
- busy  out  1  state is not IDLE.
- err  out  1  sticky; set on timeout.

Behaviour:
- Clocking and reset: single clock clk_sys; nRESET is synchronous active-low. While nRESET=0 every output is 0, the state is IDLE and the starvation counters are 0.
- State machine has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Sample the req inputs. Winner order is tile > spr > theme, unless a starvation counter has reached STARVE_MAX; that client then wins, with ties broken theme > spr.
  - Latch the winner and its address, then go to ISSUE. With no req, stay in IDLE.
  - A mem_valid pulse received in IDLE is ignored.
- Address mapping:
  - tile: mem_addr = TILE_BASE + tile_addr.
  - spr: mem_addr = SPR_BASE + spr_addr.
  - theme: mem_addr = THEME_BASE + theme_addr[17:1]; theme_addr[0] is latched as the half select.
  - Additions are MEM_AW bits wide and wrap modulo 2^MEM_AW.
- ISSUE: mem_rd=1 and mem_addr stable until a cycle with mem_ready=1; the next state is WAIT. mem_rd drops the cycle after acceptance.
- WAIT:
  - Count cycles from 0. On mem_valid, capture data into the winner's data register and go to RESP.
  - If the count reaches TIMEOUT with no mem_valid, load 32'hFFFFFFFF (theme: 16'hFFFF), set err and go to RESP.
  - mem_valid and timeout in the same cycle: mem_valid wins, err is not set.
- RESP: pulse the winner's ack for exactly one cycle, then return to IDLE.
- Starvation counters: clear the winner's counter. Increment the counter of each other client that had req=1 at arbitration, saturating at STARVE_MAX.
- Theme data: theme_data = half_select ? mem_dout[31:16] : mem_dout[15:0].
- Latency: with req rising at cycle 0, mem_ready=1 and memory latency L (mem_valid L cycles after acceptance):
  - mem_rd is high at cycle 1;
  - ack fires at cycle 2+L.
- Request rules: the requester holds its address stable while req=1. If req is still high in IDLE after an ack, that is a new access. Dropping req after arbitration does not cancel the access; the ack is still issued.
- Reset mid-operation (any state): abort to IDLE with outputs 0. A late mem_valid after reset release is ignored.

Optional Feature:
- Macro: GFX_ROM_HITCACHE_EN. Each client keeps the last completed mem word address, a valid bit and its data.
- With the macro: in IDLE, a winner whose mapped address equals its stored address (valid=1) goes straight to RESP with the stored data. This gives an ack at cycle 2 with no mem_rd. The winner's starvation counter still clears. The valid bits clear on reset and after any timeout access for that client.
- Without the macro: every request goes to memory.

Decomposition:
- Package gfx_rom_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - client id enum {CL_TILE, CL_SPR, CL_THEME};
  - default base constants and the timeout fill value 32'hFFFFFFFF.
- Sub-module gfx_rom_prio_sel: combinational winner select from the req vector and starvation counters.

Test Plan:
- tile_req=1, tile_addr=18'h00010, L=3 -> mem_rd at cycle 1 with mem_addr=22'h000010; tile_ack at cycle 5 with tile_data=mem_dout.
- tile_req, spr_req and theme_req all held high -> grant order T,T,T,T then theme once counter=4 (spr promoted next); no client waits more than 5 grants.
- theme_addr=18'h00003, mem_dout=32'hBEEF1234 -> mem_addr=22'h0C0001, theme_data=16'hBEEF.
- mem_valid withheld -> ack after TIMEOUT+1 WAIT cycles, data=32'hFFFFFFFF, err=1 and sticky; mem_valid on the exact timeout cycle -> real data, err=0.
- nRESET=0 in WAIT, then a stray mem_valid after release -> no ack, busy=0, all outputs 0.
- GFX_ROM_HITCACHE_EN defined: repeat spr_addr=19'h12345 twice -> second spr_ack at cycle 2, no mem_rd; undefined -> two memory reads.
